// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory-access stage: FSM states, access size
// codes, ALU flag indices and write-back mux selects.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ACCESS    = 2'd1,
    ST_WAIT_RESP = 2'd2
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam int unsigned FLAG_ZERO = 0;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

endpackage

// File: rtl/flag_regfile.sv
// Architectural ALU flag register plus branch-condition evaluation for
// flag-based (jt/jf) and zero-based (beq/bne) control flow.
module flag_regfile
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned FLAG_W = 6,
  parameter int unsigned FSEL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic [FSEL_W-1:0] flag_sel,
  input  logic              sel_jflag_branch,
  input  logic              sel_jt_jf,
  input  logic              sel_beq_bne,
  output logic              cond_c
);

  logic [FLAG_W-1:0] flag_q;
  logic [FLAG_W-1:0] flag_shift_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q <= '0;
    end else if (we) begin
      flag_q <= alu_flags;
    end
  end

  // Selector values beyond FLAG_W read as 0; reads see the pre-update value.
  always_comb begin
    flag_shift_c = flag_q >> flag_sel;
    if (sel_jflag_branch) begin
      cond_c = alu_flags[FLAG_ZERO] ^ sel_beq_bne;
    end else begin
      cond_c = flag_shift_c[0] ^ sel_jt_jf;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: drives the data-memory handshake, stalls EX while busy and
// registers write-back / redirect results. LAPIDO_SUBWORD_EN adds byte/half access.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned FLAG_W = 6,
  parameter int unsigned FSEL_W = 3,
  parameter int unsigned REG_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic [1:0]            in_size,
  input  logic                  in_unsigned,
  input  logic [DATA_W-1:0]     in_mem_addr,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [DATA_W-1:0]     in_alu_res,
  input  logic [FLAG_W-1:0]     in_alu_flags,
  input  logic                  in_fl_we,
  input  logic [FSEL_W-1:0]     in_flag_sel,
  input  logic                  in_is_branch,
  input  logic                  in_is_jump,
  input  logic                  in_sel_beq_bne,
  input  logic                  in_sel_jt_jf,
  input  logic                  in_sel_jflag_branch,
  input  logic [PC_W-1:0]       in_abs_addr,
  input  logic [PC_W-1:0]       in_branch_target,
  input  logic [PC_W-1:0]       in_next_pc,
  input  logic [1:0]            in_wb_res_mux,
  input  logic                  in_reg_write_enable,
  input  logic [REG_W-1:0]      in_reg_dst,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_W/8-1:0]   mem_be,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall,
  output logic                  out_valid,
  output logic                  out_reg_write_enable,
  output logic [1:0]            out_wb_res_mux,
  output logic [REG_W-1:0]      out_reg_dst,
  output logic [DATA_W-1:0]     out_alu_res,
  output logic [DATA_W-1:0]     out_mem_data,
  output logic [PC_W-1:0]       out_next_pc,
  output logic [PC_W-1:0]       out_redirect_pc,
  output logic                  out_redirect
);

  state_e state_q, state_d;

  logic                memop_c;
  logic                accept_c;
  logic                load_done_c;
  logic                cond_c;
  logic                fl_we_c;
  logic [DATA_W-1:0]   req_addr_c;
  logic [DATA_W-1:0]   req_wdata_c;
  logic [DATA_W/8-1:0] req_be_c;
  logic [DATA_W-1:0]   ld_data_c;

  assign memop_c     = in_mem_read | in_mem_write;
  assign accept_c    = (state_q == ST_IDLE) && in_valid && memop_c;
  assign load_done_c = (state_q == ST_WAIT_RESP) && mem_rvalid;
  assign fl_we_c     = in_valid && in_fl_we && !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Stall drops in the completion cycle so the held instruction retires that edge.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && memop_c) begin
          stall   = 1'b1;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        stall = 1'b1;
        if (mem_gnt) begin
          if (mem_we) begin
            stall   = 1'b0;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_RESP;
          end
        end
      end
      ST_WAIT_RESP: begin
        stall = 1'b1;
        if (mem_rvalid) begin
          stall   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef LAPIDO_SUBWORD_EN
  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned LANE_W = $clog2(NB);

  logic [1:0]        size_q;
  logic              unsigned_q;
  logic [LANE_W-1:0] off_q;
  logic [DATA_W-1:0] rshift_c;

  // Align the address to the access size and place the data in every lane.
  always_comb begin
    req_addr_c  = in_mem_addr;
    req_be_c    = '1;
    req_wdata_c = in_mem_data;
    case (in_size)
      SIZE_BYTE: begin
        req_be_c    = NB'(1) << in_mem_addr[LANE_W-1:0];
        req_wdata_c = {NB{in_mem_data[7:0]}};
      end
      SIZE_HALF: begin
        req_addr_c[0] = 1'b0;
        req_be_c      = NB'(3) << {in_mem_addr[LANE_W-1:1], 1'b0};
        req_wdata_c   = {(NB/2){in_mem_data[15:0]}};
      end
      default: req_addr_c[LANE_W-1:0] = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q     <= SIZE_WORD;
      unsigned_q <= 1'b0;
      off_q      <= '0;
    end else if (accept_c) begin
      size_q     <= in_size;
      unsigned_q <= in_unsigned;
      off_q      <= req_addr_c[LANE_W-1:0];
    end
  end

  always_comb begin
    rshift_c = mem_rdata >> {off_q, 3'b000};
    case (size_q)
      SIZE_BYTE: ld_data_c = {{(DATA_W-8){~unsigned_q & rshift_c[7]}}, rshift_c[7:0]};
      SIZE_HALF: ld_data_c = {{(DATA_W-16){~unsigned_q & rshift_c[15]}}, rshift_c[15:0]};
      default:   ld_data_c = mem_rdata;
    endcase
  end
`else
  logic unused_subword;

  assign unused_subword = ^{in_size, in_unsigned};
  assign req_addr_c     = in_mem_addr;
  assign req_be_c       = '1;
  assign req_wdata_c    = in_mem_data;
  assign ld_data_c      = mem_rdata;
`endif

  // Request fields are captured once at acceptance and held for the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_req <= (state_d == ST_ACCESS);
      if (accept_c) begin
        mem_we    <= in_mem_write;
        mem_be    <= req_be_c;
        mem_addr  <= req_addr_c;
        mem_wdata <= req_wdata_c;
      end
    end
  end

  flag_regfile #(
    .FLAG_W (FLAG_W),
    .FSEL_W (FSEL_W)
  ) u_flag_regfile (
    .clk              (clk),
    .rst              (rst),
    .we               (fl_we_c),
    .alu_flags        (in_alu_flags),
    .flag_sel         (in_flag_sel),
    .sel_jflag_branch (in_sel_jflag_branch),
    .sel_jt_jf        (in_sel_jt_jf),
    .sel_beq_bne      (in_sel_beq_bne),
    .cond_c           (cond_c)
  );

  // Write-back register: a stalled cycle inserts a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid            <= 1'b0;
      out_reg_write_enable <= 1'b0;
      out_wb_res_mux       <= '0;
      out_reg_dst          <= '0;
      out_alu_res          <= '0;
      out_next_pc          <= '0;
      out_redirect_pc      <= '0;
      out_redirect         <= 1'b0;
    end else if (!stall) begin
      out_valid            <= in_valid;
      out_reg_write_enable <= in_reg_write_enable;
      out_wb_res_mux       <= in_wb_res_mux;
      out_reg_dst          <= in_reg_dst;
      out_alu_res          <= in_alu_res;
      out_next_pc          <= in_next_pc;
      out_redirect_pc      <= in_is_jump ? in_abs_addr : in_branch_target;
      out_redirect         <= in_valid && (in_is_jump || (in_is_branch && cond_c));
    end else begin
      out_valid    <= 1'b0;
      out_redirect <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_mem_data <= '0;
    end else if (load_done_c) begin
      out_mem_data <= ld_data_c;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit: the driver predicts each
// retired instruction into a queue, a negedge monitor pops and compares.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_mem_read, in_mem_write, in_unsigned, in_fl_we;
  logic [1:0]  in_size, in_wb_res_mux;
  logic [31:0] in_mem_addr, in_mem_data, in_alu_res;
  logic [5:0]  in_alu_flags;
  logic [2:0]  in_flag_sel;
  logic        in_is_branch, in_is_jump, in_sel_beq_bne, in_sel_jt_jf, in_sel_jflag_branch;
  logic [31:0] in_abs_addr, in_branch_target, in_next_pc;
  logic        in_reg_write_enable;
  logic [4:0]  in_reg_dst;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall, out_valid, out_reg_write_enable, out_redirect;
  logic [1:0]  out_wb_res_mux;
  logic [4:0]  out_reg_dst;
  logic [31:0] out_alu_res, out_mem_data, out_next_pc, out_redirect_pc;

  always #5 clk = ~clk;

  mem_access_unit #(
    .DATA_W(32), .PC_W(32), .FLAG_W(6), .FSEL_W(3), .REG_W(5)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write), .in_size(in_size), .in_unsigned(in_unsigned),
    .in_mem_addr(in_mem_addr), .in_mem_data(in_mem_data), .in_alu_res(in_alu_res),
    .in_alu_flags(in_alu_flags), .in_fl_we(in_fl_we), .in_flag_sel(in_flag_sel),
    .in_is_branch(in_is_branch), .in_is_jump(in_is_jump), .in_sel_beq_bne(in_sel_beq_bne),
    .in_sel_jt_jf(in_sel_jt_jf), .in_sel_jflag_branch(in_sel_jflag_branch),
    .in_abs_addr(in_abs_addr), .in_branch_target(in_branch_target), .in_next_pc(in_next_pc),
    .in_wb_res_mux(in_wb_res_mux), .in_reg_write_enable(in_reg_write_enable),
    .in_reg_dst(in_reg_dst), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .stall(stall), .out_valid(out_valid),
    .out_reg_write_enable(out_reg_write_enable), .out_wb_res_mux(out_wb_res_mux),
    .out_reg_dst(out_reg_dst), .out_alu_res(out_alu_res), .out_mem_data(out_mem_data),
    .out_next_pc(out_next_pc), .out_redirect_pc(out_redirect_pc), .out_redirect(out_redirect)
  );

  typedef struct {
    logic        rd, wr, uns, fl_we, br, jmp, beq, jtjf, jfb, rwe;
    logic [1:0]  size, wbm;
    logic [31:0] addr, data, alu, abs, bt, npc;
    logic [5:0]  flags;
    logic [2:0]  fsel;
    logic [4:0]  dst;
  } instr_t;

  typedef struct {
    logic [31:0] alu, mem_data, npc, rpc;
    logic        redirect, rwe;
    logic [1:0]  wbm;
    logic [4:0]  dst;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic [5:0]  m_flags;
  logic [31:0] m_mem;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic instr_t nop_instr();
    instr_t t;
    t = '{default: '0};
    t.size = 2'b10;
    t.npc  = 32'h0000_0010;
    return t;
  endfunction

  function automatic instr_t rand_instr();
    instr_t t;
    t.rd = 1'($urandom_range(0, 1));   t.wr = 1'($urandom_range(0, 1));
    t.uns = 1'($urandom_range(0, 1));  t.fl_we = 1'($urandom_range(0, 1));
    t.br = 1'($urandom_range(0, 1));   t.jmp = 1'($urandom_range(0, 3) == 0);
    t.beq = 1'($urandom_range(0, 1));  t.jtjf = 1'($urandom_range(0, 1));
    t.jfb = 1'($urandom_range(0, 1));  t.rwe = 1'($urandom_range(0, 1));
    t.size = 2'($urandom_range(0, 2)); t.wbm = 2'($urandom_range(0, 2));
    t.addr = $urandom; t.data = $urandom; t.alu = $urandom;
    t.abs = $urandom;  t.bt = $urandom;   t.npc = $urandom;
    t.flags = 6'($urandom); t.fsel = 3'($urandom); t.dst = 5'($urandom);
    return t;
  endfunction

  // Expected loaded value from lane position, size and signedness.
  function automatic logic [31:0] ref_load(input instr_t t, input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata;
`ifdef LAPIDO_SUBWORD_EN
    if (t.size == 2'b00) begin
      v = (rdata >> (8 * (t.addr % 4))) & 32'hFF;
      if (!t.uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (t.size == 2'b01) begin
      v = (rdata >> (8 * ((t.addr % 4) & 2))) & 32'hFFFF;
      if (!t.uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
`endif
    return v;
  endfunction

  task automatic ref_req(input instr_t t, output logic [31:0] a, output logic [3:0] be,
                         output logic [31:0] wd);
    a = t.addr; be = 4'hF; wd = t.data;
`ifdef LAPIDO_SUBWORD_EN
    if (t.size == 2'b00) begin
      be = 4'(1 << (t.addr % 4)); wd = {4{t.data[7:0]}};
    end else if (t.size == 2'b01) begin
      a = t.addr & ~32'h1; be = ((t.addr % 4) >= 2) ? 4'b1100 : 4'b0011; wd = {2{t.data[15:0]}};
    end else begin
      a = t.addr & ~32'h3;
    end
`endif
  endtask

  function automatic exp_t predict(input instr_t t, input logic [31:0] rdata);
    exp_t e;
    logic c;
    int   idx;
    idx = int'(t.fsel);
    if (t.jfb) c = t.flags[0] ^ t.beq;
    else       c = ((idx < 6) ? m_flags[idx] : 1'b0) ^ t.jtjf;
    e.redirect = t.jmp | (t.br & c);
    e.rpc = t.jmp ? t.abs : t.bt;
    if (t.fl_we) m_flags = t.flags;
    if (t.rd && !t.wr) m_mem = ref_load(t, rdata);
    e.mem_data = m_mem;
    e.alu = t.alu; e.npc = t.npc; e.rwe = t.rwe; e.wbm = t.wbm; e.dst = t.dst;
    return e;
  endfunction

  task automatic drive(input instr_t t);
    in_valid = 1'b1; in_mem_read = t.rd; in_mem_write = t.wr; in_size = t.size;
    in_unsigned = t.uns; in_mem_addr = t.addr; in_mem_data = t.data; in_alu_res = t.alu;
    in_alu_flags = t.flags; in_fl_we = t.fl_we; in_flag_sel = t.fsel; in_is_branch = t.br;
    in_is_jump = t.jmp; in_sel_beq_bne = t.beq; in_sel_jt_jf = t.jtjf;
    in_sel_jflag_branch = t.jfb; in_abs_addr = t.abs; in_branch_target = t.bt;
    in_next_pc = t.npc; in_wb_res_mux = t.wbm; in_reg_write_enable = t.rwe; in_reg_dst = t.dst;
  endtask

  task automatic idle_cycle();
    drive(rand_instr());
    in_valid = 1'b0;
    mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("stall_idle_gap", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
  endtask

  // g = ACCESS cycles before grant, r = WAIT_RESP cycles before rvalid.
  task automatic run_instr(input instr_t t, input int g, input int r, input logic [31:0] rdata);
    logic        is_ld;
    logic [31:0] ea, ewd;
    logic [3:0]  ebe;
    is_ld = t.rd & ~t.wr;
    drive(t);
    exp_q.push_back(predict(t, rdata));
    if (!(t.rd | t.wr)) begin
      @(negedge clk);
      chk("stall_nonmem", 32'(stall), 32'd0);
      @(posedge clk); #1;
      return;
    end
    ref_req(t, ea, ebe, ewd);
    @(negedge clk);
    chk("stall_accept", 32'(stall), 32'd1);
    chk("req_accept", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < g; i++) begin
      mem_rvalid = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
      @(negedge clk);
      chk("req_access", 32'(mem_req), 32'd1);
      chk("stall_access", 32'(stall), 32'd1);
      @(posedge clk); #1;
    end
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    chk("req_gnt", 32'(mem_req), 32'd1);
    chk("mem_we", 32'(mem_we), 32'(t.wr));
    chk("mem_addr", mem_addr, ea);
    chk("mem_be", 32'(mem_be), 32'(ebe));
    if (t.wr) chk("mem_wdata", mem_wdata, ewd);
    chk("stall_gnt", 32'(stall), 32'(is_ld));
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    if (is_ld) begin
      for (int i = 0; i < r; i++) begin
        mem_gnt = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("req_wait", 32'(mem_req), 32'd0);
        chk("stall_wait", 32'(stall), 32'd1);
        @(posedge clk); #1;
      end
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = rdata;
      @(negedge clk);
      chk("stall_rvalid", 32'(stall), 32'd0);
      @(posedge clk); #1;
      mem_rvalid = 1'b0; mem_rdata = $urandom;
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_alu_res", out_alu_res, mon_e.alu);
        chk("out_mem_data", out_mem_data, mon_e.mem_data);
        chk("out_next_pc", out_next_pc, mon_e.npc);
        chk("out_redirect", 32'(out_redirect), 32'(mon_e.redirect));
        chk("out_redirect_pc", out_redirect_pc, mon_e.rpc);
        chk("out_reg_we", 32'(out_reg_write_enable), 32'(mon_e.rwe));
        chk("out_wb_mux", 32'(out_wb_res_mux), 32'(mon_e.wbm));
        chk("out_reg_dst", 32'(out_reg_dst), 32'(mon_e.dst));
      end
    end
  end

  initial begin
    instr_t t;
    rst = 1'b1; m_flags = '0; m_mem = '0;
    drive(nop_instr()); in_valid = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_out_mem_data", out_mem_data, 32'd0);
    chk("rst_out_redirect", 32'(out_redirect), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ALU-only instruction
    t = nop_instr(); t.alu = 32'h1234; t.rwe = 1'b1; t.dst = 5'd3;
    run_instr(t, 0, 0, 32'h0);
    idle_cycle();

    // Word load: grant after 2 cycles, response 3 cycles after grant
    t = nop_instr(); t.rd = 1'b1; t.addr = 32'h40; t.wbm = 2'd1; t.rwe = 1'b1; t.dst = 5'd7;
    run_instr(t, 2, 2, 32'hDEAD_BEEF);
    idle_cycle(); idle_cycle();

    // Flag write Z=1, then jt and jf on Z
    t = nop_instr(); t.fl_we = 1'b1; t.flags = 6'b000001;
    run_instr(t, 0, 0, 32'h0);
    t = nop_instr(); t.br = 1'b1; t.fsel = 3'd0; t.jtjf = 1'b0; t.bt = 32'h0000_0200;
    run_instr(t, 0, 0, 32'h0);
    t.jtjf = 1'b1;
    run_instr(t, 0, 0, 32'h0);
    idle_cycle();

`ifdef LAPIDO_SUBWORD_EN
    t = nop_instr(); t.rd = 1'b1; t.size = 2'b00; t.addr = 32'h43; t.uns = 1'b0;
    run_instr(t, 1, 1, 32'h80FF_FFFF);
    t = nop_instr(); t.wr = 1'b1; t.size = 2'b01; t.addr = 32'h42; t.data = 32'h0000_ABCD;
    run_instr(t, 0, 0, 32'h0);
    idle_cycle();
`endif

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end
    repeat (3) idle_cycle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // Reset during WAIT_RESP, stray response on the following cycle
    t = nop_instr(); t.rd = 1'b1; t.addr = 32'h80;
    drive(t);
    @(posedge clk); #1;
    mem_gnt = 1'b1;
    @(posedge clk); #1;
    mem_gnt = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_mem_read = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    m_flags = '0; m_mem = '0;
    @(negedge clk);
    chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_out_mem_data", out_mem_data, 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    chk("rst_drop_mem_data", out_mem_data, 32'd0);
    chk("rst_drop_mem_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    t = nop_instr(); t.br = 1'b1; t.fsel = 3'd0; t.jtjf = 1'b0; t.bt = 32'h0000_0300;
    run_instr(t, 0, 0, 32'h0);
    repeat (2) idle_cycle();
    chk("final_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
